// File: rtl/stack_pkg.sv
// Shared definitions for the stack datapath: default stack geometry and the
// opcode encodings that the control unit and the operand stack both decode.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  // ADD is a two-bit class code (3'b00x), so it lives on its own; the rest are full opcodes.
  localparam logic [1:0] OP_ADD = 2'b00;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b011,
    OP_PUSH = 3'b100,
    OP_POP  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } op_e;

  function automatic logic isAddOp(input logic [2:0] op);
    return op[2:1] == OP_ADD;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH storage for the operand stack: one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wAddr,
  input  logic [WIDTH-1:0]         i_wData,
  input  logic [$clog2(DEPTH)-1:0] i_rAddr,
  output logic [WIDTH-1:0]         o_rData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  assign o_rData = r_mem[i_rAddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack machine: Push/Pop/tos strobes from the
// control unit, registered read data one clock later, status and sticky error flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic                   tos,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   zero,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_ONE = (AW+1)'(1);
  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);

  logic [AW:0]      r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_unf;

  logic [AW:0]      w_spDec;
  logic [WIDTH-1:0] w_top;
  logic             w_empty;
  logic             w_full;
  logic             w_readTop;
  logic             w_unfEvent;
  logic             w_replace;
  logic             w_pushNew;
  logic             w_ovfEvent;
  logic             w_popOnly;
  logic             w_we;
  logic [AW-1:0]    w_wAddr;

  assign w_spDec = r_sp - SP_ONE;
  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SP_MAX);

  // Pop wins over tos, but both read the pre-write top; Push+Pop on a live stack overwrites in place.
  assign w_readTop  = (Pop | tos) & ~w_empty;
  assign w_unfEvent = (Pop | tos) & w_empty;
  assign w_replace  = Push & Pop & ~w_empty;
  assign w_pushNew  = Push & ~w_replace & ~w_full;
  assign w_ovfEvent = Push & ~w_replace & w_full;
  assign w_popOnly  = Pop & ~Push & ~w_empty;

  assign w_we    = w_replace | w_pushNew;
  assign w_wAddr = w_replace ? w_spDec[AW-1:0] : r_sp[AW-1:0];

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_wAddr(w_wAddr),
    .i_wData(din),
    .i_rAddr(w_spDec[AW-1:0]),
    .o_rData(w_top)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp   <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      if (w_readTop) begin
        r_dout <= w_top;
      end
      if (w_pushNew) begin
        r_sp <= r_sp + SP_ONE;
      end else if (w_popOnly) begin
        r_sp <= w_spDec;
      end
      if (w_ovfEvent) begin
        r_ovf <= 1'b1;
      end
      if (w_unfEvent) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign dout  = r_dout;
  assign zero  = (r_dout == '0);
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_sp;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit: hand-computed expectations for
// push/pop ordering, tos, fill/overflow, underflow, replace-top and async reset.
module tb_stack_unit;

  logic       clk;
  logic       rst;
  logic       Push;
  logic       Pop;
  logic       tos;
  logic [7:0] din;
  logic [7:0] dout;
  logic       zero;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       unf;

  int checks;
  int errors;

  stack_unit #(
    .WIDTH(8),
    .DEPTH(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .Push (Push),
    .Pop  (Pop),
    .tos  (tos),
    .din  (din),
    .dout (dout),
    .zero (zero),
    .full (full),
    .empty(empty),
    .count(count),
    .ovf  (ovf),
    .unf  (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe cycle: drive just after an edge, let the next edge take it, sample 1ns later.
  task automatic applyStimulus(input logic push, input logic pop, input logic top,
                               input logic [7:0] data);
    Push = push;
    Pop  = pop;
    tos  = top;
    din  = data;
    @(posedge clk);
    #1;
    Push = 1'b0;
    Pop  = 1'b0;
    tos  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag, input logic [7:0] expDout,
                             input logic [4:0] expCount, input logic expOvf,
                             input logic expUnf);
    checkOutput({tag, ".dout"}, 32'(dout), 32'(expDout));
    checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
    checkOutput({tag, ".zero"}, 32'(zero), 32'(expDout == 8'h00));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(expCount == 5'd0));
    checkOutput({tag, ".full"}, 32'(full), 32'(expCount == 5'd16));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvf));
    checkOutput({tag, ".unf"}, 32'(unf), 32'(expUnf));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b0;
    Push = 1'b0;
    Pop  = 1'b0;
    tos  = 1'b0;
    din  = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    checkStatus("resetHeld", 8'h00, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkStatus("idle", 8'h00, 5'd0, 1'b0, 1'b0);

    // Push two, pop two: LIFO order, one cycle after each Pop
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h05);
    checkOutput("push05.count", 32'(count), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0A);
    checkStatus("push0A", 8'h00, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("pop0A", 8'h0A, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("pop05", 8'h05, 5'd0, 1'b0, 1'b0);

    // tos leaves the stack intact
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkStatus("tos00", 8'h00, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkStatus("tos03", 8'h03, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("drain03", 8'h03, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("drain00", 8'h00, 5'd0, 1'b0, 1'b0);

    // Fill to DEPTH, overflow attempt, then drain in reverse
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
    end
    checkStatus("filled", 8'h00, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
    checkStatus("overflow", 8'h00, 5'd16, 1'b1, 1'b0);
    for (int i = 16; i >= 1; i--) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
      checkOutput($sformatf("drain%0d.count", i), 32'(count), 32'(i - 1));
    end
    checkStatus("drained", 8'h01, 5'd0, 1'b1, 1'b0);

    // Underflow: Pop then tos on empty, dout holds, later Push still works
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("popEmpty", 8'h01, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkStatus("tosEmpty", 8'h01, 5'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h07);
    checkStatus("push07", 8'h01, 5'd1, 1'b1, 1'b1);

    // Replace-top: dout gets the old top, count unchanged, new value sits on top
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h09);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h04);
    checkStatus("replace", 8'h09, 5'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("popReplaced", 8'h04, 5'd1, 1'b1, 1'b1);

    // tos with Push reads the pre-push top, then the push lands
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55);
    checkStatus("tosPush", 8'h07, 5'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("pop55", 8'h55, 5'd1, 1'b1, 1'b1);

    // tos with Pop: Pop wins, so the entry is removed
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkStatus("popTos", 8'h07, 5'd0, 1'b1, 1'b1);

    // Async reset mid-sequence, then Push+Pop on empty acts as a plain push
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h11);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkStatus("preReset", 8'h22, 5'd2, 1'b1, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkStatus("asyncReset", 8'h00, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h33);
    checkStatus("pushPopEmpty", 8'h00, 5'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkStatus("pop33", 8'h33, 5'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
